// File: rtl/min_mem_pkg.sv
// Shared definitions for the MIN processor memory subsystem: default bus
// geometry and the one-hot state encoding of the memory access controller.
package min_mem_pkg;

    // Geometry shared by the memory, the datapath and the access controller.
    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 16;
    localparam int LENW_DEF = 4;

    // Bit positions of each state inside the one-hot state vector.
    localparam int ST_IDLE     = 0;
    localparam int ST_RD_FETCH = 1;
    localparam int ST_RD_HOLD  = 2;
    localparam int ST_WR_WAIT  = 3;
    localparam int ST_WR_BEAT  = 4;
    localparam int ST_TURN     = 5;
    localparam int NSTATE      = 6;

    typedef enum logic [NSTATE-1:0] {
        IDLE     = 6'b000001,
        RD_FETCH = 6'b000010,
        RD_HOLD  = 6'b000100,
        WR_WAIT  = 6'b001000,
        WR_BEAT  = 6'b010000,
        TURN     = 6'b100000
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_bus_driver.sv
// Tristate driver for the shared memory data bus. Each bit is an explicit
// bufif1 so the bus is released to high-Z whenever oe is low.
module mem_bus_driver #(
    parameter int DW = 16
) (
    input  logic          oe,
    input  logic [DW-1:0] wdata_i,
    inout  wire  [DW-1:0] bus_io
);

    for (genvar i = 0; i < DW; i++) begin : g_bit
        bufif1 u_buf (bus_io[i], wdata_i[i], oe);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller for the MIN unified memory. Turns read/write
// burst requests into address, load and output-enable strobes, owns the
// shared bidirectional data bus and returns read data over valid/ready.
// Every strobe is a single one-hot state bit, so the memory output enable
// and the controller's bus drive can never overlap, and the FSM always
// passes through a cycle with neither active when switching direction.
module mem_access_ctrl
    import min_mem_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [LENW-1:0] req_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_load,
    output logic            mem_ctrl,
    inout  wire  [DW-1:0]   mem_data
);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   wdata_q;
    // Low during reset and for nothing else; keeps req_ready registered-only.
    logic            rst_done_q;

    assign req_ready = state_q[ST_IDLE] & rst_done_q;
    assign mem_ctrl  = state_q[ST_RD_FETCH];
    assign rd_valid  = state_q[ST_RD_HOLD];
    assign wr_ready  = state_q[ST_WR_WAIT];
    assign mem_load  = state_q[ST_WR_BEAT];
    assign done      = state_q[ST_TURN];
    assign mem_addr  = addr_q;
    assign rd_data   = rd_data_q;

    mem_bus_driver #(
        .DW (DW)
    ) u_bus_driver (
        .oe      (state_q[ST_WR_BEAT]),
        .wdata_i (wdata_q),
        .bus_io  (mem_data)
    );

    // Next-state, address and beat-counter logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = req_we ? WR_WAIT : RD_FETCH;
                end
            end
            RD_FETCH: begin
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    if (cnt_q == '0) begin
                        state_d = TURN;
                    end else begin
                        cnt_d   = cnt_q - LENW'(1);
                        addr_d  = addr_q + AW'(1);
                        state_d = RD_FETCH;
                    end
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    state_d = WR_BEAT;
                end
            end
            WR_BEAT: begin
                if (cnt_q == '0) begin
                    state_d = TURN;
                end else begin
                    cnt_d   = cnt_q - LENW'(1);
                    addr_d  = addr_q + AW'(1);
                    state_d = WR_WAIT;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address and beat-counter registers; reset abandons any burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rst_done_q <= 1'b1;
        end
    end

    // Read data is captured at the edge that closes the fetch cycle and then
    // held for the whole handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (state_q[ST_RD_FETCH]) begin
            rd_data_q <= mem_data;
        end
    end

    // Write register; only meaningful while the bus is driven in WR_BEAT.
    always_ff @(posedge clk) begin
        if (state_q[ST_WR_WAIT] && wr_valid) begin
            wdata_q <= wr_data;
        end
    end

endmodule
